// File: rtl/score_link_pkg.sv
// Shared definitions for the inter-board score link (receiver and transmitter).
package score_link_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         FRAME_LEN     = 6;
  localparam logic [7:0] MAX_PLAYER_ID = 8'd3;
  localparam logic [7:0] EMPTY_ID      = 8'h00;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    GET_ID  = 3'd1,
    GET_HI  = 3'd2,
    GET_MID = 3'd3,
    GET_LO  = 3'd4,
    GET_CHK = 3'd5
  } rx_state_e;

  function automatic logic isBcdByte(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/score_frame_rx_if.sv
// Byte-stream input and score-slot output bundle of the score frame receiver.
interface score_frame_rx_if;

  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  board_ID;
  logic [31:0] ext_data_1;
  logic [31:0] ext_data_2;
  logic        frame_ok;
  logic        frame_err;

  modport master (
    output rx_data, rx_done, board_ID,
    input  ext_data_1, ext_data_2, frame_ok, frame_err
  );

  modport slave (
    input  rx_data, rx_done, board_ID,
    output ext_data_1, ext_data_2, frame_ok, frame_err
  );

endinterface

// File: rtl/score_frame_rx.sv
// Parses 6-byte score frames from the UART byte strobe and stores remote
// players' {ID, BCD points} into two display slots.
module score_frame_rx #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = score_link_pkg::SYNC_BYTE
) (
  input  logic             pclk,
  input  logic             rst,
  score_frame_rx_if.slave  bus
);

  import score_link_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e   state_q;
  logic [7:0]  id_q, hi_q, mid_q, lo_q;
  logic [31:0] slot1_q, slot2_q, slot1_d, slot2_d;
  logic        ok_q, err_q, ok_d, err_d;
  logic [TW-1:0] tmo_q;

  logic        frameGood;
  logic [31:0] newSlot;

  // Outcome of the frame if the current byte is its checksum.
  always_comb begin
    slot1_d   = slot1_q;
    slot2_d   = slot2_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    newSlot   = {id_q, hi_q, mid_q, lo_q};
    frameGood = ((id_q ^ hi_q ^ mid_q ^ lo_q) == bus.rx_data)
              && isBcdByte(hi_q) && isBcdByte(mid_q) && isBcdByte(lo_q)
              && (id_q != EMPTY_ID) && (id_q <= MAX_PLAYER_ID);
    if (!frameGood) begin
      err_d = 1'b1;
    end else if (id_q != bus.board_ID) begin
      // An ID already on screen keeps its slot; otherwise take the first free one.
      if (id_q == slot1_q[31:24]) begin
        slot1_d = newSlot;
        ok_d    = 1'b1;
      end else if (id_q == slot2_q[31:24]) begin
        slot2_d = newSlot;
        ok_d    = 1'b1;
      end else if (slot1_q[31:24] == EMPTY_ID) begin
        slot1_d = newSlot;
        ok_d    = 1'b1;
      end else if (slot2_q[31:24] == EMPTY_ID) begin
        slot2_d = newSlot;
        ok_d    = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= HUNT;
      id_q    <= '0;
      hi_q    <= '0;
      mid_q   <= '0;
      lo_q    <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (bus.rx_done) begin
        tmo_q <= '0;
        case (state_q)
          HUNT:    if (bus.rx_data == SYNC_BYTE) state_q <= GET_ID;
          GET_ID:  begin id_q  <= bus.rx_data; state_q <= GET_HI;  end
          GET_HI:  begin hi_q  <= bus.rx_data; state_q <= GET_MID; end
          GET_MID: begin mid_q <= bus.rx_data; state_q <= GET_LO;  end
          GET_LO:  begin lo_q  <= bus.rx_data; state_q <= GET_CHK; end
          GET_CHK: begin
            slot1_q <= slot1_d;
            slot2_q <= slot2_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            state_q <= HUNT;
          end
          default: state_q <= HUNT;
        endcase
      end else if (state_q != HUNT) begin
        // A stalled sender abandons the partial frame silently.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_q   <= '0;
          state_q <= HUNT;
        end else begin
          tmo_q   <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign bus.ext_data_1 = slot1_q;
  assign bus.ext_data_2 = slot2_q;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_err  = err_q;

endmodule

// File: doc/score_frame_rx.md
Name: score_frame_rx

Overview:
Receives score frames sent by the other boards over the inter-board UART byte stream. Parses, validates and checks each frame. Places each remote player's {board_ID, 6-digit BCD points} into one of two 32-bit slots, ext_data_1 and ext_data_2. These slots feed the on-screen score text ROM. The block sits between the UART RX byte strobe and the text-rendering path, all in the pclk domain.

Parameters:
TIMEOUT_CYCLES, 100000, idle pclk cycles between bytes of a frame before the parser abandons the frame.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
pclk  input  1  pixel/system clock; all logic is clocked on the rising edge.
rst  input  1  synchronous, active-high reset.
rx_data  input  8  received byte; valid only when rx_done=1.
rx_done  input  1  one-cycle strobe: rx_data holds a new byte.
board_ID  input  8  this board's own ID (1..3).
ext_data_1  output  32  slot 1: [31:24] player ID, [23:0] six BCD digits, MSD first.
ext_data_2  output  32  slot 2: same format as slot 1.
frame_ok  output  1  one-cycle pulse: a frame was accepted and written to a slot.
frame_err  output  1  one-cycle pulse: a frame was rejected.

Behaviour:
- One clock, pclk. Reset is synchronous and active-high on rst.
- Reset values: ext_data_1 = ext_data_2 = 32'h0; frame_ok = frame_err = 0; FSM = HUNT; timeout counter = 0.
- A slot with ID byte 8'h00 is empty.
- Frame is 6 bytes: SYNC, ID, P_HI (digits 1-2), P_MID (digits 3-4), P_LO (digits 5-6), CHK.
- Checksum rule: CHK = ID ^ P_HI ^ P_MID ^ P_LO.
- FSM states: HUNT -> GET_ID -> GET_HI -> GET_MID -> GET_LO -> GET_CHK -> HUNT.
  - Each transition advances only on a clock edge where rx_done=1.
  - In HUNT, non-SYNC bytes are discarded silently.
  - After HUNT, every byte counts as payload, including a value equal to SYNC_BYTE. There is no mid-frame resync.
- Payload bytes are latched into internal registers as they arrive.
- Timeout:
  - The counter runs in every non-HUNT state and clears on each rx_done.
  - When the count reaches TIMEOUT_CYCLES without a byte, the FSM returns to HUNT.
  - No frame_err pulse; partial data is discarded.
- On the rx_done edge in GET_CHK, the frame is evaluated in that same cycle. Slot and pulse updates are registered at that edge and visible the next cycle (latency 1 cycle after the CHK strobe).
- The frame is rejected (frame_err=1, no slot change) if any of these holds:
  - checksum mismatch;
  - any BCD nibble > 9;
  - ID = 0 or ID > 3.
- If ID == board_ID: the frame is ignored. No pulse, no slot change. These are our own echoed frames.
- Slot selection for a valid foreign frame, by priority:
  1. ID equals slot 1's ID -> overwrite slot 1.
  2. Else ID equals slot 2's ID -> overwrite slot 2.
  3. Else slot 1 empty -> slot 1.
  4. Else slot 2 empty -> slot 2.
  5. Else reject with frame_err.
- A written slot holds {ID, P_HI, P_MID, P_LO}. Exactly one of frame_ok or frame_err pulses per evaluated frame.
- If rx_done=1 in the evaluation cycle, the FSM is in HUNT at that edge, so a SYNC byte there is not consumed. The sender must guarantee at least 1 idle cycle between bytes (always true for UART).
- rst asserted mid-frame: the frame is discarded and both slots clear to 0.
- board_ID changing at runtime takes effect on the next evaluated frame. Already-stored slots are not purged.

Decomposition:
- Shared package score_link_pkg holds:
  - SYNC_BYTE;
  - FRAME_LEN = 6;
  - state encoding (HUNT..GET_CHK, 3 bits);
  - MAX_PLAYER_ID = 3;
  - EMPTY_ID = 8'h00.
- The matching transmitter block uses the same package.
- Single module; no sub-module. The timeout counter and the slot-select logic are small enough to stay inline.

Test Plan:
- board_ID=1; bytes A5 02 01 23 45 65 -> ext_data_1 = 32'h02012345 one cycle after the CHK strobe; frame_ok pulses once; ext_data_2 stays 0.
- Continuing from the first test: A5 03 00 00 99 9A -> ext_data_2 = 32'h03000099. Then A5 02 00 00 10 12 -> ext_data_1 = 32'h02000010 (same-ID overwrite); ext_data_2 unchanged.
- Bad checksum A5 02 01 23 45 66 -> frame_err pulse, slots unchanged. BCD error A5 02 0A 00 00 08 -> frame_err. ID error A5 04 00 00 00 04 -> frame_err.
- board_ID=1; A5 01 00 00 01 00 -> no pulse, slots unchanged. Stray bytes 00 FF 12 before A5 -> ignored, and the following valid frame is accepted.
- A5 02 then silence for TIMEOUT_CYCLES -> FSM back in HUNT with no pulse. Then the full valid frame A5 02 01 23 45 65 -> accepted.
- Assert rst after bytes A5 02 01 -> outputs all 0. Then the remaining bytes 23 45 65 -> ignored (FSM in HUNT), no pulse.
